// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with valid/ready handshake
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      op_ctrl,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2:0]      op;
    logic [XLEN-1:0] hi, lo, mag2;
    logic            sgn1, sgn2, dbz;

    // Operand decode in the acceptance cycle
    logic            a_signed1, a_signed2, a_s1, a_s2, a_dbz;
    logic [XLEN-1:0] a_mag1, a_mag2;

    always_comb begin
        a_signed1 = (op_ctrl != 3'b011) && (op_ctrl != 3'b101) && (op_ctrl != 3'b111);
        a_signed2 = (op_ctrl == 3'b000) || (op_ctrl == 3'b001) ||
                    (op_ctrl == 3'b100) || (op_ctrl == 3'b110);
        a_s1      = a_signed1 && op1[XLEN-1];
        a_s2      = a_signed2 && op2[XLEN-1];
        a_mag1    = a_s1 ? -op1 : op1;
        a_mag2    = a_s2 ? -op2 : op2;
        a_dbz     = op_ctrl[2] && (op2 == '0);
    end

    // One radix-2 step: hi:lo is the product accumulator or remainder:quotient
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag2} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag2};
        if (op[2]) begin
            if (!div_diff[XLEN]) begin
                step_hi = div_diff[XLEN-1:0];
                step_lo = {lo[XLEN-2:0], 1'b1};
            end else begin
                step_hi = div_shift[XLEN-1:0];
                step_lo = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo[XLEN-1:1]};
        end

        prod     = {hi, lo};
        prod_fix = (sgn1 ^ sgn2) ? -prod : prod;
        case (op)
            3'b000:         fix_result = prod_fix[XLEN-1:0];
            3'b100, 3'b101: fix_result = (sgn1 ^ sgn2) ? -lo : lo;
            3'b110, 3'b111: fix_result = sgn1 ? -hi : hi;
            default:        fix_result = prod_fix[2*XLEN-1:XLEN];
        endcase
        if (dbz) fix_result = lo;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= IDLE;
            count      <= '0;
            op         <= '0;
            hi         <= '0;
            lo         <= '0;
            mag2       <= '0;
            sgn1       <= 1'b0;
            sgn2       <= 1'b0;
            dbz        <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            result     <= '0;
        end else if (flush) begin
            state      <= IDLE;
            count      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    op        <= op_ctrl;
                    sgn1      <= a_s1;
                    sgn2      <= a_s2;
                    mag2      <= a_mag2;
                    hi        <= '0;
                    count     <= '0;
                    dbz       <= a_dbz;
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                    // Divide by zero skips the iteration and resolves in FIX
                    if (a_dbz) begin
                        lo    <= op_ctrl[1] ? op1 : '1;
                        state <= FIX;
                    end else begin
                        lo    <= a_mag1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    hi    <= step_hi;
                    lo    <= step_lo;
                    count <= count + 1'b1;
                    if (count == CW'(XLEN - 1)) state <= FIX;
                end
                FIX: begin
                    result     <= fix_result;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        srst, flush, req_valid, resp_ready;
    logic        req_ready, resp_valid, busy;
    logic [2:0]  op_ctrl;
    logic [31:0] op1, op2, result;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .srst(srst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .op_ctrl(op_ctrl), .op1(op1), .op2(op2),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completed response handshake is matched against the scoreboard
    always @(negedge clk) begin
        if (resp_valid && resp_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_resp: got 0x%08h with no request outstanding", result);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (result !== e) begin
                    bad++;
                    $display("FAIL result: got 0x%08h expected 0x%08h", result, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        if (!req_ready) chk({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    // Issue one request and return once resp_valid is seen; latency counted in edges
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n = 0;
        int ready_hi = 0;
        wait_ready(name);
        req_valid = 1'b1;
        op_ctrl   = op;
        op1       = a;
        op2       = b;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        req_valid = 1'b0;
        op1       = $urandom;
        op2       = $urandom;
        op_ctrl   = 3'($urandom);
        while (n < 100) begin
            tick();
            n++;
            if (resp_valid) break;
            if (req_ready) ready_hi++;
        end
        chk({name, "_latency"}, 32'(n), 32'(lat));
        chk({name, "_req_ready_low"}, 32'(ready_hi), 32'd0);
    endtask

    initial begin
        srst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        op_ctrl = 3'b000; op1 = '0; op2 = '0;
        tick(); tick();
        srst = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);

        issue("mul",      3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        issue("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        issue("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        issue("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        issue("mul_big",  3'b000, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 33);
        issue("div",      3'b100, 32'hFFFF_FFEC, 32'd2,        32'hFFFF_FFF6, 33);
        issue("rem",      3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        issue("divu",     3'b101, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 33);
        issue("remu",     3'b111, 32'hFFFF_FFF9, 32'd2,        32'd1,         33);
        issue("div_negd", 3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        issue("rem_negd", 3'b110, 32'd7,        32'hFFFF_FFFE, 32'd1,         33);
        issue("div_zero", 3'b100, 32'd5,        32'd0,         32'hFFFF_FFFF, 1);
        issue("rem_zero", 3'b110, 32'd5,        32'd0,         32'd5,         1);
        issue("divu_zero",3'b101, 32'd9,        32'd0,         32'hFFFF_FFFF, 1);
        issue("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        issue("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);

        // Backpressure: hold the response for 5 cycles
        tick();
        resp_ready = 1'b0;
        issue("bp", 3'b000, 32'd6, 32'd9, 32'd54, 33);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid_held", 32'(resp_valid), 32'd1);
            chk("bp_result_held", result, 32'd54);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_idle_ready", 32'(req_ready), 32'd1);
        chk("bp_idle_valid", 32'(resp_valid), 32'd0);
        issue("bp_next", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        tick();

        // Flush in CALC cycle 10
        wait_ready("flush");
        req_valid = 1'b1; op_ctrl = 3'b000; op1 = 32'd3; op2 = 32'd4;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_req_ready", 32'(req_ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_resp_valid", 32'(resp_valid), 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (resp_valid) seen++;
            end
            chk("flush_no_resp", 32'(seen), 32'd0);
        end

        // Flush coincident with a request in IDLE
        req_valid = 1'b1; flush = 1'b1; op_ctrl = 3'b100; op1 = 32'd5; op2 = 32'd0;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_req_busy", 32'(busy), 32'd0);
        chk("flush_req_ready2", 32'(req_ready), 32'd1);
        tick(); tick();
        chk("flush_req_no_resp", 32'(resp_valid), 32'd0);

        // Reset during FIX
        req_valid = 1'b1; op_ctrl = 3'b000; op1 = 32'd7; op2 = 32'd3;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 32; i++) tick();
        chk("fix_busy", 32'(busy), 32'd1);
        chk("fix_no_valid", 32'(resp_valid), 32'd0);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("srst_req_ready", 32'(req_ready), 32'd1);
        chk("srst_resp_valid", 32'(resp_valid), 32'd0);
        chk("srst_busy", 32'(busy), 32'd0);
        chk("srst_result", result, 32'd0);
        for (int i = 0; i < 36; i++) tick();
        chk("srst_no_resp", 32'(resp_valid), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
